tri_bus_arbiter: RTL and testbench

TRI_BUS_ARBITER -- requirements
Module: tri_bus_arbiter

---
 rtl/tri_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_tri_bus_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter that owns one shared tristate bus on behalf of CHANNELS requesters.
// Latency: grant and oe register 1 cycle after request; data_o is a 1-cycle registered sample of bus_io.
// Backpressure: a tenure lasts while the owner keeps req high, then TURNAROUND high-Z cycles separate owners.
//
// Ports:
//   clk_i, rst_n_i  - clock and synchronous active-low reset
//   req_i           - per-channel request, bit k = channel k
//   data_i          - channel k data in [k*WIDTH +: WIDTH]
//   gnt_o, oe_o     - registered one-hot grant and bus output enable
//   bus_io          - shared tristate bus, driven only while oe_o is high
//   data_o          - bus_io sampled every rising edge
//   busy_o          - high whenever the FSM is not IDLE
//
// Optional feature: define TRI_BUS_HOLD_EN to cap a tenure at MAX_HOLD DRIVE cycles
// whenever another channel is waiting.
module tri_bus_arbiter #(
   parameter int WIDTH      = 8,
   parameter int CHANNELS   = 4,
   parameter int TURNAROUND = 1,
   parameter int MAX_HOLD   = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic [CHANNELS-1:0]       req_i,
   input  logic [CHANNELS*WIDTH-1:0] data_i,
   output logic [CHANNELS-1:0]       gnt_o,
   output logic                      oe_o,
   inout  tri   [WIDTH-1:0]          bus_io,
   output logic [WIDTH-1:0]          data_o,
   output logic                      busy_o
);

   localparam int PW = $clog2(CHANNELS);
   localparam int TW = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      TURN  = 2'd2
   } state_t;

   state_t           state;
   logic [PW-1:0]    ptr;        // last granted channel; next search starts just above it
   logic [TW-1:0]    turn_cnt;
   logic [PW-1:0]    win;
   logic             any_req;
   logic             own_req;
   logic             force_turn;
   logic [WIDTH-1:0] drive_dat;

   // First requester strictly after 'last', wrapping; 'last' itself is checked last.
   function automatic logic [PW-1:0] rr_pick(input logic [CHANNELS-1:0] r,
                                             input logic [PW-1:0]       last);
      logic [PW-1:0] pick;
      logic [PW-1:0] cand;
      logic          found;
      pick  = last;
      found = 1'b0;
      for (int i = 1; i <= CHANNELS; i++) begin
         cand = PW'((int'(last) + i) % CHANNELS);
         if (!found && r[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign win     = rr_pick(req_i, ptr);
   assign any_req = |req_i;
   assign own_req = |(req_i & gnt_o);
   assign busy_o  = (state != IDLE);

`ifdef TRI_BUS_HOLD_EN
   logic [7:0] hold_cnt;       // DRIVE cycles of the current tenure, current cycle included
   assign force_turn = (hold_cnt >= 8'(MAX_HOLD)) && (|(req_i & ~gnt_o));
`else
   assign force_turn = 1'b0;
`endif

   // Data mux is keyed off the registered grant, so the bus follows data_i combinationally.
   always_comb begin
      drive_dat = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (gnt_o[k]) drive_dat = data_i[k*WIDTH +: WIDTH];
      end
   end

   assign bus_io = oe_o ? drive_dat : {WIDTH{1'bz}};

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state    <= IDLE;
         gnt_o    <= '0;
         oe_o     <= 1'b0;
         ptr      <= PW'(CHANNELS - 1);
         turn_cnt <= '0;
         data_o   <= '0;
`ifdef TRI_BUS_HOLD_EN
         hold_cnt <= '0;
`endif
      end else begin
         data_o <= bus_io;
         case (state)
            IDLE: begin
               if (any_req) begin
                  state <= DRIVE;
                  gnt_o <= CHANNELS'(1) << win;
                  oe_o  <= 1'b1;
                  ptr   <= win;
`ifdef TRI_BUS_HOLD_EN
                  hold_cnt <= 8'd1;
`endif
               end
            end
            DRIVE: begin
               if (!own_req || force_turn) begin
                  state    <= TURN;
                  gnt_o    <= '0;
                  oe_o     <= 1'b0;
                  turn_cnt <= '0;
               end
`ifdef TRI_BUS_HOLD_EN
               else if (hold_cnt < 8'(MAX_HOLD)) begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
`endif
            end
            TURN: begin
               if (turn_cnt == TW'(TURNAROUND - 1)) begin
                  turn_cnt <= '0;
                  if (any_req) begin
                     state <= DRIVE;
                     gnt_o <= CHANNELS'(1) << win;
                     oe_o  <= 1'b1;
                     ptr   <= win;
`ifdef TRI_BUS_HOLD_EN
                     hold_cnt <= 8'd1;
`endif
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  turn_cnt <= turn_cnt + TW'(1);
               end
            end
            default: begin
               state <= IDLE;
               gnt_o <= '0;
               oe_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed bench for tri_bus_arbiter: two instances (TURNAROUND 1 and 3) with external bus drivers.
// Outputs sampled 1 time unit after each rising edge; inputs changed at the same point.
// An external 8'h3C driver is enabled only when the DUT is expected to release the bus.
module tb_tri_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_a, req_b;
   logic [31:0] dat_a, dat_b;
   wire  [3:0]  gnt_a, gnt_b;
   wire         oe_a, oe_b, busy_a, busy_b;
   wire  [7:0]  dout_a, dout_b;
   tri   [7:0]  bus_a, bus_b;
   logic        ext_a_en, ext_b_en;
   logic [7:0]  ext_val;

   int n_tests = 0;
   int n_fail  = 0;

   assign bus_a = ext_a_en ? ext_val : 8'hzz;
   assign bus_b = ext_b_en ? ext_val : 8'hzz;

   always #5 clk = ~clk;

   tri_bus_arbiter #(.WIDTH(8), .CHANNELS(4), .TURNAROUND(1), .MAX_HOLD(4)) u_dut_a (
      .clk_i(clk), .rst_n_i(rst_n), .req_i(req_a), .data_i(dat_a),
      .gnt_o(gnt_a), .oe_o(oe_a), .bus_io(bus_a), .data_o(dout_a), .busy_o(busy_a)
   );

   tri_bus_arbiter #(.WIDTH(8), .CHANNELS(4), .TURNAROUND(3), .MAX_HOLD(16)) u_dut_b (
      .clk_i(clk), .rst_n_i(rst_n), .req_i(req_b), .data_i(dat_b),
      .gnt_o(gnt_b), .oe_o(oe_b), .bus_io(bus_b), .data_o(dout_b), .busy_o(busy_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] tmp;
      logic [3:0]  exp_g;
      int          ch;
      int          p;

      rst_n = 1'b0; req_a = '0; req_b = '0; dat_a = '0; dat_b = '0;
      ext_a_en = 1'b0; ext_b_en = 1'b0; ext_val = 8'h3C;
      tick(); tick();

      // Reset state
      chk("rst_gnt",   32'(gnt_a),  32'h0);
      chk("rst_oe",    32'(oe_a),   32'h0);
      chk("rst_busy",  32'(busy_a), 32'h0);
      chk("rst_dout",  32'(dout_a), 32'h0);
      chk("rst_gnt_b", 32'(gnt_b),  32'h0);
      chk("rst_busy_b",32'(busy_b), 32'h0);
      chk("rst_dout_b",32'(dout_b), 32'h0);

      // Single request, ch0 = A5
      rst_n = 1'b1; dat_a[7:0] = 8'hA5; req_a = 4'b0001;
      tick();
      chk("single_gnt",  32'(gnt_a),  32'h1);
      chk("single_oe",   32'(oe_a),   32'h1);
      chk("single_bus",  32'(bus_a),  32'hA5);
      chk("single_busy", 32'(busy_a), 32'h1);
      tick();
      chk("single_dout", 32'(dout_a), 32'hA5);
      chk("single_hold", 32'(gnt_a),  32'h1);
      req_a = 4'b0000;
      tick();
      chk("drop_gnt",  32'(gnt_a),  32'h0);
      chk("drop_oe",   32'(oe_a),   32'h0);
      chk("drop_busy", 32'(busy_a), 32'h1);
      ext_a_en = 1'b1; #1;
      chk("drop_busz", 32'(bus_a),  32'h3C);
      tick();
      chk("idle_busy", 32'(busy_a), 32'h0);
      chk("idle_dout", 32'(dout_a), 32'h3C);
      ext_a_en = 1'b0;

      // Round robin with all four requesting, 3-cycle tenures
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; dat_a = 32'h44332211; req_a = 4'b1111;
      tick();
      for (int t = 0; t < 5; t++) begin
         ch  = t % 4;
         tmp = dat_a;
         chk("rr_gnt",  32'(gnt_a), 32'(4'b0001 << ch));
         chk("rr_bus",  32'(bus_a), 32'(tmp[ch*8 +: 8]));
         tick();
         chk("rr_gnt2", 32'(gnt_a), 32'(4'b0001 << ch));
         tick();
         chk("rr_gnt3", 32'(gnt_a), 32'(4'b0001 << ch));
         req_a[ch] = 1'b0;
         tick();
         chk("rr_turn_oe", 32'(oe_a), 32'h0);
         ext_a_en = 1'b1; #1;
         chk("rr_turn_bus", 32'(bus_a), 32'h3C);
         ext_a_en = 1'b0;
         req_a[ch] = 1'b1;
         tick();
      end
      req_a = 4'b0000;
      tick(); tick();

      // Mid-tenure reset with ch1 still requesting
      req_a = 4'b0010;
      tick();
      chk("mid_gnt", 32'(gnt_a), 32'h2);
      rst_n = 1'b0;
      tick();
      chk("mrst_gnt",  32'(gnt_a),  32'h0);
      chk("mrst_oe",   32'(oe_a),   32'h0);
      chk("mrst_busy", 32'(busy_a), 32'h0);
      ext_a_en = 1'b1; #1;
      chk("mrst_bus",  32'(bus_a),  32'h3C);
      rst_n = 1'b1; req_a = 4'b0000;
      tick();
      chk("mrst_dout", 32'(dout_a), 32'h3C);
      ext_a_en = 1'b0;

      // ch0 and ch2 both hold requests for 20 cycles
      req_a = 4'b0101;
      tick();
      for (int i = 0; i < 20; i++) begin
`ifdef TRI_BUS_HOLD_EN
         p = i % 5;
         if (p == 4) exp_g = 4'b0000;
         else if (((i / 5) % 2) == 1) exp_g = 4'b0100;
         else exp_g = 4'b0001;
`else
         p = i;
         exp_g = 4'b0001;
`endif
         chk("hold_gnt", 32'(gnt_a), 32'(exp_g));
         tick();
      end
      req_a = 4'b0000;
      tick(); tick();

      // TURNAROUND=3 instance: ch1 hands over to ch2
      dat_b[15:8] = 8'h5A; dat_b[23:16] = 8'hC3; req_b = 4'b0010;
      tick();
      chk("t3_gnt1", 32'(gnt_b), 32'h2);
      chk("t3_bus1", 32'(bus_b), 32'h5A);
      req_b = 4'b0100;
      tick();
      for (int k = 0; k < 3; k++) begin
         chk("t3_turn_oe",  32'(oe_b),  32'h0);
         chk("t3_turn_gnt", 32'(gnt_b), 32'h0);
         ext_b_en = 1'b1; #1;
         chk("t3_turn_bus", 32'(bus_b), 32'h3C);
         ext_b_en = 1'b0;
         tick();
      end
      chk("t3_gnt2", 32'(gnt_b), 32'h4);
      chk("t3_oe2",  32'(oe_b),  32'h1);
      chk("t3_bus2", 32'(bus_b), 32'hC3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
